// File: rtl/updn_counter.sv
// updn_counter: up/down counter over 0..MAX_VAL with wrap or saturate boundaries, tc pulse and sticky ovf/unf flags.
// Define UPDN_CMP_EN to add the cmp_val input and the registered cmp_hit output.
module updn_counter #(
  parameter int          WIDTH   = 8,
  parameter int unsigned MAX_VAL = 255,
  parameter int          SAT     = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             updwn,
  input  logic             ld,
  input  logic [WIDTH-1:0] load_val,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic             unf
`ifdef UPDN_CMP_EN
  ,
  input  logic [WIDTH-1:0] cmp_val,
  output logic             cmp_hit
`endif
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
  localparam bit SATB = SAT != 0;
  logic             at_max, at_zero, up_evt, dn_evt;
  logic [WIDTH-1:0] q_nxt, up_nxt, dn_nxt;
  assign at_max  = q == MAX;
  assign at_zero = q == '0;
  // Load takes priority over counting, so a boundary is only an event when ld is low.
  assign up_evt  = en & ~ld & ~updwn & at_max;
  assign dn_evt  = en & ~ld & updwn & at_zero;
  assign up_nxt  = at_max ? (SATB ? q : '0) : q + 1'b1;
  assign dn_nxt  = at_zero ? (SATB ? q : MAX) : q - 1'b1;
  assign q_nxt   = ld ? (load_val > MAX ? MAX : load_val) : !en ? q : updwn ? dn_nxt : up_nxt;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      q   <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      q   <= q_nxt;
      tc  <= up_evt | dn_evt;
      ovf <= up_evt | (ovf & ~flag_clr);
      unf <= dn_evt | (unf & ~flag_clr);
    end
`ifdef UPDN_CMP_EN
  always_ff @(posedge clk or posedge clr)
    if (clr) cmp_hit <= 1'b0;
    else     cmp_hit <= q_nxt == cmp_val;
`endif
endmodule

// File: tb/tb_updn_counter.sv
// tb_updn_counter: directed checks of updn_counter (WIDTH=4, MAX_VAL=9) with a wrapping and a saturating instance.
module tb_updn_counter;
  logic       clk = 1'b0, clr, en, updwn, ld, flag_clr;
  logic [3:0] load_val, cmp_val;
  logic [3:0] qw, qs;
  logic       tcw, ovw, unw, hitw, tcs, ovs, uns, hits;
  int         n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  updn_counter #(.WIDTH(4), .MAX_VAL(9), .SAT(0)) u_wrap (
    .clk(clk), .clr(clr), .en(en), .updwn(updwn), .ld(ld), .load_val(load_val),
    .flag_clr(flag_clr), .q(qw), .tc(tcw), .ovf(ovw), .unf(unw)
`ifdef UPDN_CMP_EN
    , .cmp_val(cmp_val), .cmp_hit(hitw)
`endif
  );

  updn_counter #(.WIDTH(4), .MAX_VAL(9), .SAT(1)) u_sat (
    .clk(clk), .clr(clr), .en(en), .updwn(updwn), .ld(ld), .load_val(load_val),
    .flag_clr(flag_clr), .q(qs), .tc(tcs), .ovf(ovs), .unf(uns)
`ifdef UPDN_CMP_EN
    , .cmp_val(cmp_val), .cmp_hit(hits)
`endif
  );

`ifndef UPDN_CMP_EN
  assign hitw = 1'b0;
  assign hits = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (qw !== 4'd0) begin n_err++; $display("FAIL reset_qw: got %0d want 0", qw); end
    n_cmp++; if ({tcw, ovw, unw} !== 3'b000) begin n_err++; $display("FAIL reset_flags_w: got %b want 000", {tcw, ovw, unw}); end
    n_cmp++; if (qs !== 4'd0) begin n_err++; $display("FAIL reset_qs: got %0d want 0", qs); end
    n_cmp++; if ({tcs, ovs, uns} !== 3'b000) begin n_err++; $display("FAIL reset_flags_s: got %b want 000", {tcs, ovs, uns}); end
    tick();
    clr = 1'b0;
  endtask

  task automatic test_wrap_up();
    en = 1'b1; updwn = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_cmp++; if (qw !== 4'(i % 10)) begin n_err++; $display("FAIL wrap_up_q[%0d]: got %0d want %0d", i, qw, i % 10); end
      n_cmp++; if (tcw !== (i == 10)) begin n_err++; $display("FAIL wrap_up_tc[%0d]: got %b want %b", i, tcw, i == 10); end
    end
    n_cmp++; if (ovw !== 1'b1) begin n_err++; $display("FAIL wrap_up_ovf: got %b want 1", ovw); end
    n_cmp++; if (qs !== 4'd9 || ovs !== 1'b1) begin n_err++; $display("FAIL sat_up_hold: got q=%0d ovf=%b want q=9 ovf=1", qs, ovs); end
    en = 1'b0;
    tick();
    n_cmp++; if ({qw, tcw, ovw} !== {4'd0, 1'b0, 1'b1}) begin n_err++; $display("FAIL hold_after_wrap: got q=%0d tc=%b ovf=%b want q=0 tc=0 ovf=1", qw, tcw, ovw); end
  endtask

  task automatic test_sat_down();
    logic [3:0] exp_qs [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
    logic [3:0] exp_qw [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
    logic       exp_ts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       exp_tw [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    ld = 1'b1; load_val = 4'd2;
    tick();
    ld = 1'b0;
    n_cmp++; if (qs !== 4'd2 || tcs !== 1'b0) begin n_err++; $display("FAIL load2: got q=%0d tc=%b want q=2 tc=0", qs, tcs); end
    en = 1'b1; updwn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (qs !== exp_qs[i] || tcs !== exp_ts[i]) begin n_err++; $display("FAIL sat_down[%0d]: got q=%0d tc=%b want q=%0d tc=%b", i, qs, tcs, exp_qs[i], exp_ts[i]); end
      n_cmp++; if (qw !== exp_qw[i] || tcw !== exp_tw[i]) begin n_err++; $display("FAIL wrap_down[%0d]: got q=%0d tc=%b want q=%0d tc=%b", i, qw, tcw, exp_qw[i], exp_tw[i]); end
    end
    n_cmp++; if (uns !== 1'b1 || unw !== 1'b1) begin n_err++; $display("FAIL down_unf: got sat=%b wrap=%b want 1 1", uns, unw); end
    en = 1'b0;
  endtask

  task automatic test_load();
    ld = 1'b1; load_val = 4'd14; flag_clr = 1'b1;
    tick();
    n_cmp++; if (qw !== 4'd9 || qs !== 4'd9) begin n_err++; $display("FAIL load_clamp: got wrap=%0d sat=%0d want 9 9", qw, qs); end
    n_cmp++; if ({tcw, ovw, unw} !== 3'b000) begin n_err++; $display("FAIL load_flags: got %b want 000", {tcw, ovw, unw}); end
    flag_clr = 1'b0; en = 1'b1; updwn = 1'b0; load_val = 4'd3;
    tick();
    n_cmp++; if (qw !== 4'd3 || qs !== 4'd3) begin n_err++; $display("FAIL load_over_en: got wrap=%0d sat=%0d want 3 3", qw, qs); end
    n_cmp++; if ({tcw, ovw, tcs, ovs} !== 4'b0000) begin n_err++; $display("FAIL load_over_en_flags: got %b want 0000", {tcw, ovw, tcs, ovs}); end
    ld = 1'b0; en = 1'b0;
  endtask

  task automatic test_async_clr();
    ld = 1'b1; load_val = 4'd9;
    tick();
    ld = 1'b0; en = 1'b1; updwn = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    n_cmp++; if (qw !== 4'd6 || ovw !== 1'b1) begin n_err++; $display("FAIL pre_clr: got q=%0d ovf=%b want q=6 ovf=1", qw, ovw); end
    #2 clr = 1'b1;
    #1;
    n_cmp++; if ({qw, tcw, ovw, unw} !== 7'd0) begin n_err++; $display("FAIL async_clr: got q=%0d tc=%b ovf=%b unf=%b want all 0", qw, tcw, ovw, unw); end
    tick();
    n_cmp++; if (qw !== 4'd0) begin n_err++; $display("FAIL clr_held: got q=%0d want 0", qw); end
    clr = 1'b0;
    tick();
    n_cmp++; if (qw !== 4'd1) begin n_err++; $display("FAIL clr_resume: got q=%0d want 1", qw); end
    en = 1'b0;
  endtask

  task automatic test_flag_clr();
    ld = 1'b1; load_val = 4'd8;
    tick();
    ld = 1'b0; en = 1'b1; updwn = 1'b0;
    tick();
    n_cmp++; if (qw !== 4'd9 || ovw !== 1'b0) begin n_err++; $display("FAIL pre_wrap: got q=%0d ovf=%b want q=9 ovf=0", qw, ovw); end
    flag_clr = 1'b1;
    tick();
    n_cmp++; if ({qw, tcw, ovw} !== {4'd0, 1'b1, 1'b1}) begin n_err++; $display("FAIL set_beats_clr: got q=%0d tc=%b ovf=%b want q=0 tc=1 ovf=1", qw, tcw, ovw); end
    en = 1'b0;
    tick();
    n_cmp++; if (ovw !== 1'b0 || tcw !== 1'b0) begin n_err++; $display("FAIL flag_clr_alone: got ovf=%b tc=%b want 0 0", ovw, tcw); end
    flag_clr = 1'b0;
  endtask

  task automatic test_direction();
    logic       dir [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] exp [4] = '{4'd1, 4'd0, 4'd1, 4'd2};
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      updwn = dir[i];
      tick();
      n_cmp++; if (qw !== exp[i] || tcw !== 1'b0) begin n_err++; $display("FAIL direction[%0d]: got q=%0d tc=%b want q=%0d tc=0", i, qw, tcw, exp[i]); end
    end
    en = 1'b0;
  endtask

`ifdef UPDN_CMP_EN
  task automatic test_cmp();
    logic [3:0] exp_q [4] = '{4'd4, 4'd5, 4'd6, 4'd7};
    cmp_val = 4'd5; ld = 1'b1; load_val = 4'd3;
    tick();
    n_cmp++; if (qw !== 4'd3 || hitw !== 1'b0) begin n_err++; $display("FAIL cmp_load: got q=%0d hit=%b want q=3 hit=0", qw, hitw); end
    ld = 1'b0; en = 1'b1; updwn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (qw !== exp_q[i] || hitw !== (exp_q[i] == 4'd5)) begin n_err++; $display("FAIL cmp_hit[%0d]: got q=%0d hit=%b want q=%0d hit=%b", i, qw, hitw, exp_q[i], exp_q[i] == 4'd5); end
    end
    en = 1'b0;
  endtask
`endif

  initial begin
    clr = 1'b1; en = 1'b0; updwn = 1'b0; ld = 1'b0; flag_clr = 1'b0;
    load_val = 4'd0; cmp_val = 4'd0;
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_load();
    test_async_clr();
    test_flag_clr();
    test_direction();
`ifdef UPDN_CMP_EN
    test_cmp();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/updn_counter.md
UPDN_COUNTER -- requirements
Module: updn_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (2..32).
REQ-002 SHALL have parameter MAX_VAL, default 255, terminal count; counting range 0..MAX_VAL; legal range 1..2**WIDTH-1.
REQ-003 SHALL have parameter SAT, default 0, boundary mode: 0 = wrap, 1 = saturate.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-005 SHALL have port clr, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port en, input, 1, count enable.
REQ-007 SHALL have port updwn, input, 1, direction: 0 = up, 1 = down.
REQ-008 SHALL have port ld, input, 1, synchronous load strobe.
REQ-009 SHALL have port load_val, input, WIDTH, load value.
REQ-010 SHALL have port flag_clr, input, 1, synchronous clear of sticky flags.
REQ-011 SHALL have port q, output, WIDTH, count value, registered.
REQ-012 SHALL have port tc, output, 1, terminal-count pulse, registered.
REQ-013 SHALL have port ovf, output, 1, sticky up-boundary flag, registered.
REQ-014 SHALL have port unf, output, 1, sticky down-boundary flag, registered.
REQ-015 SHALL have port cmp_val, input, WIDTH, compare value (UPDN_CMP_EN only).
REQ-016 SHALL have port cmp_hit, output, 1, compare match, registered (UPDN_CMP_EN only).

Function
REQ-017 SHALL use per-edge priority: clr > ld > en > hold.
REQ-018 SHALL, on ld, set q to load_val if load_val <= MAX_VAL, else MAX_VAL; no tc, ovf or unf effect.
REQ-019 SHALL, on en with updwn=0 and q < MAX_VAL, set q to q+1; with updwn=1 and q > 0, set q to q-1.
REQ-020 SHALL treat en, updwn=0, q=MAX_VAL as an up-boundary event: q to 0 (SAT=0) or held at MAX_VAL (SAT=1).
REQ-021 SHALL treat en, updwn=1, q=0 as a down-boundary event: q to MAX_VAL (SAT=0) or held at 0 (SAT=1).
REQ-022 SHALL assert tc for exactly one cycle following each boundary event and deassert it in every other cycle, including hold and load cycles.
REQ-023 SHALL set ovf on an up-boundary event and unf on a down-boundary event; both stay set until flag_clr or clr.
REQ-024 SHALL let a set win over flag_clr in the same cycle, so the flag reads 1 afterwards.
REQ-025 SHALL, with en=0 and ld=0, hold q, ovf and unf and drive tc to 0.
REQ-026 SHALL sample updwn each edge; a direction change takes effect on the same edge with no dead cycle.
REQ-027 SHALL perform all arithmetic modulo the range 0..MAX_VAL; q never exceeds MAX_VAL.
REQ-028 SHALL produce q one edge after ld or en (latency 1).

Reset
REQ-029 SHALL, while clr=1, immediately force q=0, tc=0, ovf=0, unf=0 and cmp_hit=0, independent of clk.
REQ-030 SHALL discard any pending load or count on assertion of clr mid-operation; counting resumes on the first rising edge with clr=0.

Configuration
REQ-031 SHALL, with macro UPDN_CMP_EN defined, provide cmp_val and cmp_hit, where cmp_hit is registered from next-q == cmp_val so that it is high exactly in the cycles where q == cmp_val.
REQ-032 SHALL, without UPDN_CMP_EN, omit cmp_val, cmp_hit and the comparator; all other behaviour is unchanged.

Verification (WIDTH=4, MAX_VAL=9)
REQ-033 SHALL cover: SAT=0, up from 0, 10 enabled edges -> q returns to 0, tc=1 for one cycle after the 9->0 edge, ovf=1.
REQ-034 SHALL cover: SAT=1, down from 2, 4 edges -> q = 1, 0, 0, 0; tc pulses after the 3rd and 4th edges; unf=1.
REQ-035 SHALL cover: ld=1, load_val=14 -> q=9; ld=1 and en=1 together with load_val=3 -> q=3, no tc.
REQ-036 SHALL cover: clr asserted between edges at q=6 with ovf=1 -> q=0 and ovf=0 before the next edge.
REQ-037 SHALL cover: flag_clr=1 in the same cycle as a 9->0 wrap -> ovf stays 1; flag_clr alone on the next cycle -> ovf=0.
REQ-038 SHALL cover: UPDN_CMP_EN defined, cmp_val=5, up from 3 -> cmp_hit=1 only while q=5.
